// File: rtl/mc_control_unit_if.sv
// Control/status bundle between the multicycle control FSM and the datapath.
// The control unit uses the master modport; the datapath uses the slave modport.
interface mc_control_unit_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       alu_overflow;
   logic       alu_zero;
   logic       mem_ready;

   logic       pc_write;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mdr_load;
   logic       a_load;
   logic       b_load;
   logic       alu_out_load;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic [1:0] pc_source;
   logic       reg_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       epc_write;
   logic [1:0] cause;
   logic       halted;
   logic [3:0] state_dbg;

   modport master (
      input  op, funct, alu_overflow, alu_zero, mem_ready,
      output pc_write, iord, mem_read, mem_write, ir_write, mdr_load,
             a_load, b_load, alu_out_load, alu_src_a, alu_src_b, alu_op,
             pc_source, reg_write, reg_dst, mem_to_reg, epc_write, cause,
             halted, state_dbg
   );

   modport slave (
      output op, funct, alu_overflow, alu_zero, mem_ready,
      input  pc_write, iord, mem_read, mem_write, ir_write, mdr_load,
             a_load, b_load, alu_out_load, alu_src_a, alu_src_b, alu_op,
             pc_source, reg_write, reg_dst, mem_to_reg, epc_write, cause,
             halted, state_dbg
   );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM with variable-latency memory handshake,
// memory-wait timeout to HALT, bne/addi decode and overflow/illegal-op exceptions.
module mc_control_unit #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter bit          EXC_ENABLE  = 1'b1
) (
   input logic            clk,
   input logic            reset,
   mc_control_unit_if.master bus
);

   localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT - 1);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      LW_WB    = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      I_EXEC   = 4'd8,
      I_WB     = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      EXC      = 4'd12,
      HALT     = 4'd13
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    cause_q, cause_d;
   logic          timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         cnt_q   <= '0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      cnt_d   = cnt_q;
      timeout = (MEM_TIMEOUT != 0) && (cnt_q == WAIT_LIMIT) && !bus.mem_ready;
      case (state_q)
         FETCH: begin
            if (bus.mem_ready)  state_d = DECODE;
            else if (timeout)   state_d = HALT;
         end
         DECODE: begin
            case (bus.op)
               OP_RTYPE:      state_d = R_EXEC;
               OP_LW, OP_SW:  state_d = MEM_ADDR;
               OP_BEQ, OP_BNE: state_d = BRANCH;
               OP_J:          state_d = JUMP;
               OP_ADDI:       state_d = I_EXEC;
               default: begin
                  if (EXC_ENABLE) begin
                     state_d = EXC;
                     cause_d = 2'b01;
                  end else begin
                     state_d = FETCH;
                  end
               end
            endcase
         end
         MEM_ADDR: state_d = (bus.op == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD: begin
            if (bus.mem_ready)  state_d = LW_WB;
            else if (timeout)   state_d = HALT;
         end
         MEM_WR: begin
            if (bus.mem_ready)  state_d = FETCH;
            else if (timeout)   state_d = HALT;
         end
         R_EXEC: begin
            if (EXC_ENABLE && bus.alu_overflow &&
                (bus.funct == 6'h20 || bus.funct == 6'h22)) begin
               state_d = EXC;
               cause_d = 2'b10;
            end else begin
               state_d = R_WB;
            end
         end
         I_EXEC: begin
            if (EXC_ENABLE && bus.alu_overflow) begin
               state_d = EXC;
               cause_d = 2'b10;
            end else begin
               state_d = I_WB;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
      // Any state change counts as entry into a new access, so the counter restarts.
      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q != HALT)
         cnt_d = cnt_q + CW'(1);
   end

   always_comb begin
      bus.pc_write     = 1'b0;
      bus.iord         = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.ir_write     = 1'b0;
      bus.mdr_load     = 1'b0;
      bus.a_load       = 1'b0;
      bus.b_load       = 1'b0;
      bus.alu_out_load = 1'b0;
      bus.alu_src_a    = 1'b0;
      bus.alu_src_b    = 2'b00;
      bus.alu_op       = 3'b000;
      bus.pc_source    = 2'b00;
      bus.reg_write    = 1'b0;
      bus.reg_dst      = 1'b0;
      bus.mem_to_reg   = 1'b0;
      bus.epc_write    = 1'b0;
      bus.halted       = 1'b0;
      bus.cause        = reset ? 2'b00 : cause_q;
      bus.state_dbg    = reset ? 4'd0 : state_q;
      if (!reset) begin
         case (state_q)
            FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            DECODE: begin
               bus.a_load       = 1'b1;
               bus.b_load       = 1'b1;
               bus.alu_out_load = 1'b1;
               bus.alu_src_b    = 2'b11;
            end
            MEM_ADDR: begin
               bus.alu_src_a    = 1'b1;
               bus.alu_src_b    = 2'b10;
               bus.alu_out_load = 1'b1;
            end
            MEM_RD: begin
               bus.mem_read = 1'b1;
               bus.iord     = 1'b1;
               bus.mdr_load = bus.mem_ready;
            end
            LW_WB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
               bus.mem_write = 1'b1;
               bus.iord      = 1'b1;
            end
            R_EXEC: begin
               bus.alu_src_a    = 1'b1;
               bus.alu_op       = 3'b010;
               bus.alu_out_load = 1'b1;
            end
            R_WB: begin
               bus.reg_write = 1'b1;
               bus.reg_dst   = 1'b1;
            end
            I_EXEC: begin
               bus.alu_src_a    = 1'b1;
               bus.alu_src_b    = 2'b10;
               bus.alu_out_load = 1'b1;
            end
            I_WB:   bus.reg_write = 1'b1;
            BRANCH: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 3'b001;
               bus.pc_source = 2'b01;
               bus.pc_write  = (bus.op == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
            end
            JUMP: begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'b10;
            end
            EXC: begin
               bus.epc_write = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.alu_op    = 3'b001;
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'b11;
            end
            HALT:    bus.halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: each cycle compares state, the packed
// control strobes and cause against hand-written per-state expectations.
module tb_mc_control_unit;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   mc_control_unit_if bus_if ();

   mc_control_unit #(
      .MEM_TIMEOUT (4),
      .EXC_ENABLE  (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MADDR = 4'd2,
                          S_MRD   = 4'd3,  S_LWWB   = 4'd4,  S_MWR   = 4'd5,
                          S_REX   = 4'd6,  S_RWB    = 4'd7,  S_IEX   = 4'd8,
                          S_IWB   = 4'd9,  S_BR     = 4'd10, S_J     = 4'd11,
                          S_EXC   = 4'd12, S_HALT   = 4'd13;

   // Field order: pcw iord mrd mwr irw mdr al bl aol asa asb aop pcs rw rd m2r epc hlt
   function automatic logic [21:0] w(
      input logic pcw, input logic iord, input logic mrd, input logic mwr,
      input logic irw, input logic mdr, input logic al, input logic bl,
      input logic aol, input logic asa, input logic [1:0] asb,
      input logic [2:0] aop, input logic [1:0] pcs, input logic rw,
      input logic rd, input logic m2r, input logic epc, input logic hlt);
      return {pcw, iord, mrd, mwr, irw, mdr, al, bl, aol, asa, asb, aop, pcs,
              rw, rd, m2r, epc, hlt};
   endfunction

   function automatic logic [21:0] obs();
      return {bus_if.pc_write, bus_if.iord, bus_if.mem_read, bus_if.mem_write,
              bus_if.ir_write, bus_if.mdr_load, bus_if.a_load, bus_if.b_load,
              bus_if.alu_out_load, bus_if.alu_src_a, bus_if.alu_src_b,
              bus_if.alu_op, bus_if.pc_source, bus_if.reg_write, bus_if.reg_dst,
              bus_if.mem_to_reg, bus_if.epc_write, bus_if.halted};
   endfunction

   logic [21:0] W_ZERO, W_FS, W_FR, W_DEC, W_MADDR, W_MRDS, W_MRDR, W_LWWB,
                W_MWR, W_REX, W_RWB, W_IEX, W_IWB, W_BRT, W_BRN, W_J, W_EXC, W_HALT;

   initial begin
      W_ZERO  = w(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0,0);
      W_FS    = w(0,0,1,0,0,0,0,0,0,0,2'b01,3'b000,2'b00,0,0,0,0,0);
      W_FR    = w(1,0,1,0,1,0,0,0,0,0,2'b01,3'b000,2'b00,0,0,0,0,0);
      W_DEC   = w(0,0,0,0,0,0,1,1,1,0,2'b11,3'b000,2'b00,0,0,0,0,0);
      W_MADDR = w(0,0,0,0,0,0,0,0,1,1,2'b10,3'b000,2'b00,0,0,0,0,0);
      W_MRDS  = w(0,1,1,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0,0);
      W_MRDR  = w(0,1,1,0,0,1,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0,0);
      W_LWWB  = w(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,0,1,0,0);
      W_MWR   = w(0,1,0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0,0);
      W_REX   = w(0,0,0,0,0,0,0,0,1,1,2'b00,3'b010,2'b00,0,0,0,0,0);
      W_RWB   = w(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,1,0,0,0);
      W_IEX   = w(0,0,0,0,0,0,0,0,1,1,2'b10,3'b000,2'b00,0,0,0,0,0);
      W_IWB   = w(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,1,0,0,0,0);
      W_BRT   = w(1,0,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0,0,0,0,0);
      W_BRN   = w(0,0,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0,0,0,0,0);
      W_J     = w(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,0,0,0,0);
      W_EXC   = w(1,0,0,0,0,0,0,0,0,0,2'b01,3'b001,2'b11,0,0,0,1,0);
      W_HALT  = w(0,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0,1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Checks one cycle at the falling edge, then advances to just past the next rising edge.
   task automatic cyc(input string tag, input logic [3:0] st, input logic [21:0] wd,
                      input logic [1:0] cs);
      @(negedge clk);
      check({tag, ".state"}, 32'(bus_if.state_dbg), 32'(st));
      check({tag, ".ctl"},   32'(obs()),            32'(wd));
      check({tag, ".cause"}, 32'(bus_if.cause),     32'(cs));
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] funct,
                            input logic ovf, input logic zero);
      bus_if.op           = op;
      bus_if.funct        = funct;
      bus_if.alu_overflow = ovf;
      bus_if.alu_zero     = zero;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset = 1'b1;
      bus_if.mem_ready = 1'b0;
      set_instr(6'h00, 6'h20, 1'b0, 1'b0);

      repeat (3) cyc("reset", S_FETCH, W_ZERO, 2'b00);
      reset = 1'b0;
      bus_if.mem_ready = 1'b1;

      // add, no overflow
      cyc("add.f", S_FETCH, W_FR, 2'b00);
      cyc("add.d", S_DECODE, W_DEC, 2'b00);
      cyc("add.x", S_REX, W_REX, 2'b00);
      cyc("add.wb", S_RWB, W_RWB, 2'b00);

      // lw with two stall cycles in MEM_RD
      set_instr(6'h23, 6'h00, 1'b0, 1'b0);
      cyc("lw.f", S_FETCH, W_FR, 2'b00);
      cyc("lw.d", S_DECODE, W_DEC, 2'b00);
      cyc("lw.a", S_MADDR, W_MADDR, 2'b00);
      bus_if.mem_ready = 1'b0;
      cyc("lw.s1", S_MRD, W_MRDS, 2'b00);
      cyc("lw.s2", S_MRD, W_MRDS, 2'b00);
      bus_if.mem_ready = 1'b1;
      cyc("lw.r", S_MRD, W_MRDR, 2'b00);
      cyc("lw.wb", S_LWWB, W_LWWB, 2'b00);

      set_instr(6'h2B, 6'h00, 1'b0, 1'b0);
      cyc("sw.f", S_FETCH, W_FR, 2'b00);
      cyc("sw.d", S_DECODE, W_DEC, 2'b00);
      cyc("sw.a", S_MADDR, W_MADDR, 2'b00);
      cyc("sw.w", S_MWR, W_MWR, 2'b00);

      set_instr(6'h04, 6'h00, 1'b0, 1'b1);
      cyc("beq1.f", S_FETCH, W_FR, 2'b00);
      cyc("beq1.d", S_DECODE, W_DEC, 2'b00);
      cyc("beq1.b", S_BR, W_BRT, 2'b00);
      set_instr(6'h05, 6'h00, 1'b0, 1'b1);
      cyc("bne1.f", S_FETCH, W_FR, 2'b00);
      cyc("bne1.d", S_DECODE, W_DEC, 2'b00);
      cyc("bne1.b", S_BR, W_BRN, 2'b00);
      set_instr(6'h05, 6'h00, 1'b0, 1'b0);
      cyc("bne0.f", S_FETCH, W_FR, 2'b00);
      cyc("bne0.d", S_DECODE, W_DEC, 2'b00);
      cyc("bne0.b", S_BR, W_BRT, 2'b00);
      set_instr(6'h04, 6'h00, 1'b0, 1'b0);
      cyc("beq0.f", S_FETCH, W_FR, 2'b00);
      cyc("beq0.d", S_DECODE, W_DEC, 2'b00);
      cyc("beq0.b", S_BR, W_BRN, 2'b00);

      set_instr(6'h02, 6'h00, 1'b0, 1'b0);
      cyc("j.f", S_FETCH, W_FR, 2'b00);
      cyc("j.d", S_DECODE, W_DEC, 2'b00);
      cyc("j.j", S_J, W_J, 2'b00);

      set_instr(6'h08, 6'h00, 1'b0, 1'b0);
      cyc("addi.f", S_FETCH, W_FR, 2'b00);
      cyc("addi.d", S_DECODE, W_DEC, 2'b00);
      cyc("addi.x", S_IEX, W_IEX, 2'b00);
      cyc("addi.wb", S_IWB, W_IWB, 2'b00);

      // addu overflow is not trapped
      set_instr(6'h00, 6'h21, 1'b1, 1'b0);
      cyc("addu.f", S_FETCH, W_FR, 2'b00);
      cyc("addu.d", S_DECODE, W_DEC, 2'b00);
      cyc("addu.x", S_REX, W_REX, 2'b00);
      cyc("addu.wb", S_RWB, W_RWB, 2'b00);

      // exceptions
      set_instr(6'h08, 6'h00, 1'b1, 1'b0);
      cyc("addiov.f", S_FETCH, W_FR, 2'b00);
      cyc("addiov.d", S_DECODE, W_DEC, 2'b00);
      cyc("addiov.x", S_IEX, W_IEX, 2'b00);
      cyc("addiov.e", S_EXC, W_EXC, 2'b10);
      set_instr(6'h3F, 6'h00, 1'b0, 1'b0);
      cyc("ill.f", S_FETCH, W_FR, 2'b10);
      cyc("ill.d", S_DECODE, W_DEC, 2'b10);
      cyc("ill.e", S_EXC, W_EXC, 2'b01);
      set_instr(6'h00, 6'h22, 1'b1, 1'b0);
      cyc("subov.f", S_FETCH, W_FR, 2'b01);
      cyc("subov.d", S_DECODE, W_DEC, 2'b01);
      cyc("subov.x", S_REX, W_REX, 2'b01);
      cyc("subov.e", S_EXC, W_EXC, 2'b10);

      // fetch timeout: 4 waiting cycles then HALT until reset
      bus_if.mem_ready = 1'b0;
      repeat (4) cyc("to.f", S_FETCH, W_FS, 2'b10);
      cyc("to.h1", S_HALT, W_HALT, 2'b10);
      bus_if.mem_ready = 1'b1;
      repeat (2) cyc("to.h2", S_HALT, W_HALT, 2'b10);
      reset = 1'b1;
      cyc("to.rst", S_FETCH, W_ZERO, 2'b00);
      reset = 1'b0;
      bus_if.mem_ready = 1'b0;
      set_instr(6'h02, 6'h00, 1'b0, 1'b0);
      repeat (3) cyc("nto.f", S_FETCH, W_FS, 2'b00);
      bus_if.mem_ready = 1'b1;
      cyc("nto.r", S_FETCH, W_FR, 2'b00);
      cyc("nto.d", S_DECODE, W_DEC, 2'b00);
      cyc("nto.j", S_J, W_J, 2'b00);

      // reset in the middle of a stalled store
      set_instr(6'h3F, 6'h00, 1'b0, 1'b0);
      cyc("ill2.f", S_FETCH, W_FR, 2'b00);
      cyc("ill2.d", S_DECODE, W_DEC, 2'b00);
      cyc("ill2.e", S_EXC, W_EXC, 2'b01);
      set_instr(6'h2B, 6'h00, 1'b0, 1'b0);
      cyc("swr.f", S_FETCH, W_FR, 2'b01);
      cyc("swr.d", S_DECODE, W_DEC, 2'b01);
      cyc("swr.a", S_MADDR, W_MADDR, 2'b01);
      bus_if.mem_ready = 1'b0;
      cyc("swr.s", S_MWR, W_MWR, 2'b01);
      reset = 1'b1;
      cyc("swr.rst", S_FETCH, W_ZERO, 2'b00);
      reset = 1'b0;
      bus_if.mem_ready = 1'b1;
      cyc("swr.f2", S_FETCH, W_FR, 2'b00);
      cyc("swr.d2", S_DECODE, W_DEC, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
